// File: rtl/sp_tracker_pkg.sv
// Shared state, direction and axis encodings for the two-axis solar tracker.
package sp_tracker_pkg;

   typedef enum logic [2:0] {
      ST_MANUAL = 3'b000,
      ST_START  = 3'b001,
      ST_MOVE   = 3'b010,
      ST_SETTLE = 3'b011,
      ST_SAMPLE = 3'b100,
      ST_HOLD   = 3'b101
   } state_e;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_NEG  = 2'b01,
      DIR_POS  = 2'b10
   } dir_e;

   localparam logic AXIS_H = 1'b0;
   localparam logic AXIS_V = 1'b1;

endpackage

// File: rtl/sp_tracker_ctrl_if.sv
// ADC sample stream feeding the tracker: one sample word plus its valid strobe.
interface sp_tracker_ctrl_if #(
   parameter int ADC_W = 12
);
   logic [ADC_W-1:0] V_in;
   logic             V_valid;

   modport master (output V_in, output V_valid);
   modport slave  (input  V_in, input  V_valid);
endinterface

// File: rtl/sp_tracker_ctrl_servo_pwm.sv
// Servo PWM generator: free-running frame counter with a per-frame shadow of the target width.
module servo_pwm #(
   parameter int POS_W      = 21,
   parameter int PWM_PERIOD = 2_000_000,
   parameter int POS_INIT   = 150_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [POS_W-1:0] target,
   output logic             servo_out
);

   localparam logic [POS_W-1:0] CNT_LAST   = POS_W'(PWM_PERIOD - 1);
   localparam logic [POS_W-1:0] SHADOW_RST = POS_W'(POS_INIT);

   logic [POS_W-1:0] cnt_q, cnt_d;
   logic [POS_W-1:0] shadow_q, shadow_d;
   logic             out_q, out_d;

   // The shadow only follows the target on the last count so a frame never changes width midway.
   always_comb begin
      cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + POS_W'(1);
      shadow_d = (cnt_q == CNT_LAST) ? target : shadow_q;
      out_d    = (cnt_q < shadow_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= SHADOW_RST;
         out_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
      end
   end

   assign servo_out = out_q;

endmodule

// File: rtl/sp_tracker_ctrl.sv
// Two-axis perturb-and-observe solar tracker with manual button jogging and periodic re-scan.
module sp_tracker_ctrl
   import sp_tracker_pkg::*;
#(
   parameter int ADC_W      = 12,
   parameter int POS_W      = 21,
   parameter int PWM_PERIOD = 2_000_000,
   parameter int POS_MIN    = 100_000,
   parameter int POS_MAX    = 200_000,
   parameter int POS_INIT   = 150_000,
   parameter int STEP       = 1_000,
   parameter int SETTLE     = 2_000_000,
   parameter int HOLD       = 50_000_000,
   parameter int HYST       = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               BTN_L,
   input  logic               BTN_R,
   input  logic               BTN_U,
   input  logic               BTN_D,
   input  logic               BTN_C,
   sp_tracker_ctrl_if.slave   adc,
   output logic               SERVO_H,
   output logic               SERVO_V,
   output logic [POS_W-1:0]   servo_position_H,
   output logic [POS_W-1:0]   servo_position_V,
   output logic [ADC_W-1:0]   max_V_in,
   output logic [1:0]         direction_lr,
   output logic [1:0]         direction_ud,
   output logic [2:0]         STAT,
   output logic               auto_active
);

   localparam int XW  = POS_W + 1;
   localparam int AW1 = ADC_W + 1;

   localparam logic [XW-1:0]    MIN_X    = XW'(POS_MIN);
   localparam logic [XW-1:0]    MAX_X    = XW'(POS_MAX);
   localparam logic [XW-1:0]    STEP_X   = XW'(STEP);
   localparam logic [POS_W-1:0] INIT_P   = POS_W'(POS_INIT);
   localparam logic [AW1-1:0]   HYST_X   = AW1'(HYST);
   localparam logic [31:0]      SETTLE_T = 32'(SETTLE);
   localparam logic [31:0]      HOLD_T   = 32'(HOLD);

   // One guard bit so neither the step up nor the step down can wrap before clamping.
   function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic up);
      logic [XW-1:0] px;
      logic [XW-1:0] r;
      px = {1'b0, p};
      if (up) r = (px + STEP_X > MAX_X) ? MAX_X : px + STEP_X;
      else    r = (px < MIN_X + STEP_X) ? MIN_X : px - STEP_X;
      return r[POS_W-1:0];
   endfunction

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_h_q, pos_h_d, pos_v_q, pos_v_d, prev_q, prev_d;
   logic [ADC_W-1:0] best_q, best_d;
   logic             axis_q, axis_d, dir_up_q, dir_up_d;
   logic [1:0]       fails_q, fails_d;
   logic             conv_h_q, conv_h_d, conv_v_q, conv_v_d;
   logic [31:0]      timer_q, timer_d;
   dir_e             dir_lr_q, dir_lr_d, dir_ud_q, dir_ud_d;
   logic [4:0]       btn_prev_q, btn_prev_d;

   logic [4:0]       btn_cur, btn_edge;
   logic             l_edge, r_edge, u_edge, d_edge, c_edge;
   logic [POS_W-1:0] cur_pos, moved_pos, restore_pos;
   logic             gain, do_fail;

   assign btn_cur  = {BTN_C, BTN_U, BTN_D, BTN_L, BTN_R};
   assign btn_edge = btn_cur & ~btn_prev_q;
   assign r_edge   = btn_edge[0];
   assign l_edge   = btn_edge[1];
   assign d_edge   = btn_edge[2];
   assign u_edge   = btn_edge[3];
   assign c_edge   = btn_edge[4];

   assign cur_pos   = (axis_q == AXIS_V) ? pos_v_q : pos_h_q;
   assign moved_pos = step_pos(cur_pos, dir_up_q);
   assign gain      = {1'b0, adc.V_in} > ({1'b0, best_q} + HYST_X);

   // Next-state logic; a BTN_C edge outranks everything else, including a coincident sample.
   always_comb begin
      state_d     = state_q;
      pos_h_d     = pos_h_q;
      pos_v_d     = pos_v_q;
      prev_d      = prev_q;
      best_d      = best_q;
      axis_d      = axis_q;
      dir_up_d    = dir_up_q;
      fails_d     = fails_q;
      conv_h_d    = conv_h_q;
      conv_v_d    = conv_v_q;
      timer_d     = timer_q;
      btn_prev_d  = btn_cur;
      do_fail     = 1'b0;
      restore_pos = prev_q;
      dir_lr_d    = dir_lr_q;
      dir_ud_d    = dir_ud_q;

      if (c_edge && state_q != ST_MANUAL) begin
         state_d = ST_MANUAL;
         best_d  = '0;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_MANUAL: begin
               if (c_edge) begin
                  state_d = ST_START;
               end else begin
                  if (l_edge && !r_edge)      pos_h_d = step_pos(pos_h_q, 1'b0);
                  else if (r_edge && !l_edge) pos_h_d = step_pos(pos_h_q, 1'b1);
                  if (d_edge && !u_edge)      pos_v_d = step_pos(pos_v_q, 1'b0);
                  else if (u_edge && !d_edge) pos_v_d = step_pos(pos_v_q, 1'b1);
                  if (adc.V_valid && adc.V_in > best_q) best_d = adc.V_in;
               end
            end
            ST_START: begin
               if (adc.V_valid) begin
                  best_d   = adc.V_in;
                  axis_d   = AXIS_H;
                  dir_up_d = 1'b1;
                  fails_d  = '0;
                  conv_h_d = 1'b0;
                  conv_v_d = 1'b0;
                  state_d  = ST_MOVE;
               end
            end
            ST_MOVE: begin
               prev_d = cur_pos;
               if (moved_pos == cur_pos) begin
                  do_fail     = 1'b1;
                  restore_pos = cur_pos;
               end else begin
                  if (axis_q == AXIS_V) pos_v_d = moved_pos;
                  else                  pos_h_d = moved_pos;
                  timer_d = SETTLE_T;
                  state_d = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (timer_q > 32'd1) begin
                  timer_d = timer_q - 32'd1;
               end else begin
                  timer_d = '0;
                  state_d = ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (adc.V_valid) begin
                  if (gain) begin
                     best_d  = adc.V_in;
                     fails_d = '0;
                     if (axis_q == AXIS_H) conv_v_d = 1'b0;
                     else                  conv_h_d = 1'b0;
                     state_d = ST_MOVE;
                  end else begin
                     do_fail = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (timer_q > 32'd1) begin
                  timer_d = timer_q - 32'd1;
               end else begin
                  timer_d = '0;
                  state_d = ST_START;
               end
            end
            default: state_d = ST_MANUAL;
         endcase

         // Two fails in a row mean this axis sits on a local peak; hand over to the other axis.
         if (do_fail) begin
            if (axis_q == AXIS_V) pos_v_d = restore_pos;
            else                  pos_h_d = restore_pos;
            if (fails_q == 2'd1) begin
               if (axis_q == AXIS_H) conv_h_d = 1'b1;
               else                  conv_v_d = 1'b1;
               axis_d   = ~axis_q;
               fails_d  = '0;
               dir_up_d = 1'b1;
            end else begin
               dir_up_d = ~dir_up_q;
               fails_d  = fails_q + 2'd1;
            end
            if (conv_h_d && conv_v_d) begin
               state_d = ST_HOLD;
               timer_d = HOLD_T;
            end else begin
               state_d = ST_MOVE;
            end
         end
      end

      if (pos_h_d > pos_h_q)          dir_lr_d = DIR_POS;
      else if (pos_h_d < pos_h_q)     dir_lr_d = DIR_NEG;
      else if (state_q == ST_MANUAL)  dir_lr_d = DIR_NONE;
      if (pos_v_d > pos_v_q)          dir_ud_d = DIR_POS;
      else if (pos_v_d < pos_v_q)     dir_ud_d = DIR_NEG;
      else if (state_q == ST_MANUAL)  dir_ud_d = DIR_NONE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_MANUAL;
         pos_h_q    <= INIT_P;
         pos_v_q    <= INIT_P;
         prev_q     <= INIT_P;
         best_q     <= '0;
         axis_q     <= AXIS_H;
         dir_up_q   <= 1'b1;
         fails_q    <= '0;
         conv_h_q   <= 1'b0;
         conv_v_q   <= 1'b0;
         timer_q    <= '0;
         dir_lr_q   <= DIR_NONE;
         dir_ud_q   <= DIR_NONE;
         btn_prev_q <= '0;
      end else begin
         state_q    <= state_d;
         pos_h_q    <= pos_h_d;
         pos_v_q    <= pos_v_d;
         prev_q     <= prev_d;
         best_q     <= best_d;
         axis_q     <= axis_d;
         dir_up_q   <= dir_up_d;
         fails_q    <= fails_d;
         conv_h_q   <= conv_h_d;
         conv_v_q   <= conv_v_d;
         timer_q    <= timer_d;
         dir_lr_q   <= dir_lr_d;
         dir_ud_q   <= dir_ud_d;
         btn_prev_q <= btn_prev_d;
      end
   end

   servo_pwm #(
      .POS_W      (POS_W),
      .PWM_PERIOD (PWM_PERIOD),
      .POS_INIT   (POS_INIT)
   ) u_pwm_h (
      .clk       (CLK),
      .rst       (RST),
      .target    (pos_h_q),
      .servo_out (SERVO_H)
   );

   servo_pwm #(
      .POS_W      (POS_W),
      .PWM_PERIOD (PWM_PERIOD),
      .POS_INIT   (POS_INIT)
   ) u_pwm_v (
      .clk       (CLK),
      .rst       (RST),
      .target    (pos_v_q),
      .servo_out (SERVO_V)
   );

   assign servo_position_H = pos_h_q;
   assign servo_position_V = pos_v_q;
   assign max_V_in         = best_q;
   assign direction_lr     = dir_lr_q;
   assign direction_ud     = dir_ud_q;
   assign STAT             = state_q;
   assign auto_active      = (state_q != ST_MANUAL);

endmodule

// File: tb/tb_sp_tracker_ctrl.sv
// Directed bench for sp_tracker_ctrl: manual jog table, PWM frames, auto convergence and mode corners.
module tb_sp_tracker_ctrl;

   localparam logic [2:0] S_MANUAL = 3'b000;
   localparam logic [2:0] S_START  = 3'b001;
   localparam logic [2:0] S_MOVE   = 3'b010;
   localparam logic [2:0] S_SETTLE = 3'b011;
   localparam logic [2:0] S_SAMPLE = 3'b100;
   localparam logic [2:0] S_HOLD   = 3'b101;

   logic        CLK = 1'b0;
   logic        RST;
   logic        BTN_L, BTN_R, BTN_U, BTN_D, BTN_C;
   logic        SERVO_H, SERVO_V;
   logic [20:0] servo_position_H, servo_position_V;
   logic [11:0] max_V_in;
   logic [1:0]  direction_lr, direction_ud;
   logic [2:0]  STAT;
   logic        auto_active;

   int n_checks = 0;
   int n_fails  = 0;

   sp_tracker_ctrl_if #(.ADC_W(12)) adc_if ();

   sp_tracker_ctrl #(
      .ADC_W(12), .POS_W(21), .PWM_PERIOD(100), .POS_MIN(10), .POS_MAX(20),
      .POS_INIT(15), .STEP(1), .SETTLE(4), .HOLD(8), .HYST(2)
   ) dut (
      .CLK(CLK), .RST(RST),
      .BTN_L(BTN_L), .BTN_R(BTN_R), .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_C(BTN_C),
      .adc(adc_if),
      .SERVO_H(SERVO_H), .SERVO_V(SERVO_V),
      .servo_position_H(servo_position_H), .servo_position_V(servo_position_V),
      .max_V_in(max_V_in),
      .direction_lr(direction_lr), .direction_ud(direction_ud),
      .STAT(STAT), .auto_active(auto_active)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   typedef struct {
      logic       l, r, u, d;
      int         exp_h, exp_v;
      logic [1:0] exp_lr, exp_ud;
      bit         chk_dir;
   } vec_t;

   vec_t vecs [0:17];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Drive one button pattern for a single cycle; returns at the negedge after the acting edge.
   task automatic apply_stimulus(input logic l, input logic r, input logic u, input logic d, input logic c);
      BTN_L = l; BTN_R = r; BTN_U = u; BTN_D = d; BTN_C = c;
      @(negedge CLK);
      BTN_L = 0; BTN_R = 0; BTN_U = 0; BTN_D = 0; BTN_C = 0;
   endtask

   task automatic do_reset();
      RST = 1;
      BTN_L = 0; BTN_R = 0; BTN_U = 0; BTN_D = 0; BTN_C = 0;
      adc_if.V_valid = 0; adc_if.V_in = '0;
      repeat (2) @(negedge CLK);
      RST = 0;
   endtask

   function automatic logic [11:0] panel_v(input int h, input int v);
      int dh, dv, r;
      dh = (h > 18) ? h - 18 : 18 - h;
      dv = (v > 12) ? v - 12 : 12 - v;
      r  = 1000 - 10 * dh - 10 * dv;
      if (r < 0) r = 0;
      return 12'(r);
   endfunction

   // Panel model answers every START/SAMPLE cycle until the requested state is observed.
   task automatic run_plant(input logic [2:0] stop, input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         adc_if.V_valid = 0;
         if (STAT == stop) begin
            ok = 1;
            return;
         end
         if (STAT == S_START || STAT == S_SAMPLE) begin
            adc_if.V_in    = panel_v(int'(servo_position_H), int'(servo_position_V));
            adc_if.V_valid = 1;
         end
      end
   endtask

   task automatic find_rise(output bit ok);
      logic prev;
      prev = SERVO_H;
      ok   = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (SERVO_H && !prev) begin
            ok = 1;
            return;
         end
         prev = SERVO_H;
      end
   endtask

   task automatic send_sample(input logic [11:0] v);
      adc_if.V_in    = v;
      adc_if.V_valid = 1;
      @(negedge CLK);
      adc_if.V_valid = 0;
   endtask

   initial begin
      bit ok;
      int hi_h, hi_v, n;

      vecs[0]  = '{0, 1, 0, 0, 16, 15, 2'b10, 2'b00, 1};
      vecs[1]  = '{0, 1, 0, 0, 17, 15, 2'b10, 2'b00, 1};
      vecs[2]  = '{0, 1, 0, 0, 18, 15, 2'b10, 2'b00, 1};
      vecs[3]  = '{0, 1, 0, 0, 19, 15, 2'b10, 2'b00, 1};
      vecs[4]  = '{0, 1, 0, 0, 20, 15, 2'b10, 2'b00, 1};
      vecs[5]  = '{0, 1, 0, 0, 20, 15, 2'b00, 2'b00, 0};
      vecs[6]  = '{0, 1, 0, 0, 20, 15, 2'b00, 2'b00, 0};
      vecs[7]  = '{1, 1, 0, 0, 20, 15, 2'b00, 2'b00, 1};
      vecs[8]  = '{1, 0, 0, 0, 19, 15, 2'b01, 2'b00, 1};
      vecs[9]  = '{0, 0, 1, 0, 19, 16, 2'b00, 2'b10, 1};
      vecs[10] = '{0, 0, 0, 1, 19, 15, 2'b00, 2'b01, 1};
      vecs[11] = '{0, 0, 1, 1, 19, 15, 2'b00, 2'b00, 1};
      vecs[12] = '{0, 0, 0, 1, 19, 14, 2'b00, 2'b01, 1};
      vecs[13] = '{0, 0, 0, 1, 19, 13, 2'b00, 2'b01, 1};
      vecs[14] = '{0, 0, 0, 1, 19, 12, 2'b00, 2'b01, 1};
      vecs[15] = '{0, 0, 0, 1, 19, 11, 2'b00, 2'b01, 1};
      vecs[16] = '{0, 0, 0, 1, 19, 10, 2'b00, 2'b01, 1};
      vecs[17] = '{0, 0, 0, 1, 19, 10, 2'b00, 2'b00, 0};

      RST = 1;
      BTN_L = 0; BTN_R = 0; BTN_U = 0; BTN_D = 0; BTN_C = 0;
      adc_if.V_valid = 0; adc_if.V_in = '0;
      repeat (2) @(negedge CLK);
      check_output("rst_stat", STAT, S_MANUAL);
      check_output("rst_auto", auto_active, 0);
      check_output("rst_pos_h", servo_position_H, 15);
      check_output("rst_pos_v", servo_position_V, 15);
      check_output("rst_max", max_V_in, 0);
      check_output("rst_dir_lr", direction_lr, 0);
      check_output("rst_dir_ud", direction_ud, 0);
      check_output("rst_servo_h", SERVO_H, 0);
      check_output("rst_servo_v", SERVO_V, 0);
      RST = 0;

      $display("[TB] manual jog table");
      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, 1'b0);
         check_output($sformatf("jog%0d_h", i), servo_position_H, vecs[i].exp_h);
         check_output($sformatf("jog%0d_v", i), servo_position_V, vecs[i].exp_v);
         if (vecs[i].chk_dir) begin
            check_output($sformatf("jog%0d_lr", i), direction_lr, vecs[i].exp_lr);
            check_output($sformatf("jog%0d_ud", i), direction_ud, vecs[i].exp_ud);
         end
         tick();
         if (vecs[i].chk_dir) begin
            check_output($sformatf("jog%0d_lr_idle", i), direction_lr, 0);
            check_output($sformatf("jog%0d_ud_idle", i), direction_ud, 0);
         end
      end

      $display("[TB] pwm frames");
      do_reset();
      find_rise(ok);
      check_output("pwm_rise_a", ok, 1);
      hi_h = 0; hi_v = 0;
      for (int i = 0; i < 100; i++) begin
         if (i > 0) tick();
         hi_h += int'(SERVO_H); hi_v += int'(SERVO_V);
      end
      check_output("pwm_frame_a_h", hi_h, 15);
      check_output("pwm_frame_a_v", hi_v, 15);
      find_rise(ok);
      check_output("pwm_rise_b", ok, 1);
      hi_h = 0;
      for (int i = 0; i < 100; i++) begin
         if (i > 0) tick();
         if (i == 50) BTN_R = 1;
         if (i == 51) BTN_R = 0;
         hi_h += int'(SERVO_H);
      end
      check_output("pwm_frame_b_h", hi_h, 15);
      check_output("pwm_target_b", servo_position_H, 16);
      find_rise(ok);
      check_output("pwm_rise_c", ok, 1);
      hi_h = 0;
      for (int i = 0; i < 100; i++) begin
         if (i > 0) tick();
         hi_h += int'(SERVO_H);
      end
      check_output("pwm_frame_c_h", hi_h, 16);

      $display("[TB] auto convergence");
      do_reset();
      apply_stimulus(0, 0, 0, 0, 1);
      run_plant(S_HOLD, 3000, ok);
      check_output("conv_reached_hold", ok, 1);
      check_output("conv_stat", STAT, S_HOLD);
      check_output("conv_pos_h", servo_position_H, 18);
      check_output("conv_pos_v", servo_position_V, 12);
      check_output("conv_max", max_V_in, 1000);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         n++;
         if (STAT == S_START) break;
      end
      check_output("hold_cycles", n, 8);

      $display("[TB] hysteresis boundary");
      do_reset();
      apply_stimulus(0, 0, 0, 0, 1);
      check_output("hy_start", STAT, S_START);
      check_output("hy_auto", auto_active, 1);
      send_sample(12'd500);
      check_output("hy_move0", STAT, S_MOVE);
      check_output("hy_best0", max_V_in, 500);
      check_output("hy_h_before", servo_position_H, 15);
      tick();
      check_output("hy_settle0", STAT, S_SETTLE);
      check_output("hy_h16", servo_position_H, 16);
      check_output("hy_lr_pos", direction_lr, 2'b10);
      repeat (4) tick();
      check_output("hy_sample0", STAT, S_SAMPLE);
      send_sample(12'd503);
      check_output("hy_gain_move", STAT, S_MOVE);
      check_output("hy_gain_best", max_V_in, 503);
      tick();
      check_output("hy_h17", servo_position_H, 17);
      send_sample(12'd4000);
      check_output("hy_drop_stat", STAT, S_SETTLE);
      check_output("hy_drop_best", max_V_in, 503);
      repeat (3) tick();
      check_output("hy_sample1", STAT, S_SAMPLE);
      send_sample(12'd505);
      check_output("hy_fail_move", STAT, S_MOVE);
      check_output("hy_fail_h", servo_position_H, 16);
      check_output("hy_fail_lr", direction_lr, 2'b01);
      check_output("hy_fail_best", max_V_in, 503);
      tick();
      check_output("hy_rev_stat", STAT, S_SETTLE);
      check_output("hy_rev_h", servo_position_H, 15);
      check_output("hy_rev_lr", direction_lr, 2'b01);

      $display("[TB] clamped move");
      do_reset();
      repeat (5) begin
         apply_stimulus(0, 1, 0, 0, 0);
         tick();
      end
      check_output("clamp_h20", servo_position_H, 20);
      apply_stimulus(0, 0, 0, 0, 1);
      send_sample(12'd500);
      check_output("clamp_move0", STAT, S_MOVE);
      tick();
      check_output("clamp_move1", STAT, S_MOVE);
      check_output("clamp_h_held", servo_position_H, 20);
      tick();
      check_output("clamp_settle", STAT, S_SETTLE);
      check_output("clamp_h19", servo_position_H, 19);
      check_output("clamp_lr", direction_lr, 2'b01);

      $display("[TB] abort to manual");
      do_reset();
      apply_stimulus(0, 0, 0, 0, 1);
      send_sample(12'd500);
      tick();
      check_output("ab_settle", STAT, S_SETTLE);
      BTN_C = 1;
      adc_if.V_in = 12'd3000;
      adc_if.V_valid = 1;
      tick();
      BTN_C = 0;
      adc_if.V_valid = 0;
      check_output("ab_stat", STAT, S_MANUAL);
      check_output("ab_auto", auto_active, 0);
      check_output("ab_h", servo_position_H, 16);
      check_output("ab_v", servo_position_V, 15);
      check_output("ab_max", max_V_in, 0);
      tick();
      check_output("ab_lr_idle", direction_lr, 0);
      send_sample(12'd700);
      check_output("man_max_700", max_V_in, 700);
      send_sample(12'd300);
      check_output("man_max_keep", max_V_in, 700);

      $display("[TB] reset during auto");
      apply_stimulus(0, 0, 0, 0, 1);
      send_sample(12'd500);
      tick();
      check_output("mr_settle", STAT, S_SETTLE);
      RST = 1;
      BTN_R = 1;
      adc_if.V_in = 12'd900;
      adc_if.V_valid = 1;
      tick();
      check_output("mr_stat", STAT, S_MANUAL);
      check_output("mr_h", servo_position_H, 15);
      check_output("mr_max", max_V_in, 0);
      check_output("mr_lr", direction_lr, 0);
      RST = 0;
      BTN_R = 0;
      adc_if.V_valid = 0;
      tick();
      check_output("mr_h_after", servo_position_H, 15);
      check_output("mr_stat_after", STAT, S_MANUAL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
